// File: rtl/inst_encoder_loader.sv
// Encodes symbolic instruction commands into 32-bit MIPS words and writes them sequentially into IM.
// Optional readback verification of every written word is compiled in with `define INST_ENC_VERIFY_EN.
module inst_encoder_loader #(
    parameter int AW   = 10,
    parameter int ID_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [ID_W-1:0] cmd_id,
    input  logic [4:0]      cmd_rs,
    input  logic [4:0]      cmd_rt,
    input  logic [4:0]      cmd_rd,
    input  logic [4:0]      cmd_shamt,
    input  logic [15:0]     cmd_imm,
    input  logic [25:0]     cmd_target,
    input  logic            cmd_last,
    output logic            im_we,
    output logic [AW-1:0]   im_addr,
    output logic [31:0]     im_wdata,
    output logic            im_re,
    input  logic [31:0]     im_rdata,
    output logic            busy,
    output logic            done,
    output logic [AW:0]     count,
    output logic            err_illegal,
    output logic            err_wrap,
    output logic            err_verify
);

`ifdef INST_ENC_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE, ACCEPT, WRITE, VERIFY_RD, VERIFY_CMP, DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, ACCEPT, WRITE, DONE
    } state_t;
`endif

    state_t state, state_nx;

    logic [AW-1:0] addr;
    logic          last_q;
    logic          handshake;

    logic [31:0] id_ext;
    logic        r_type, i_type, j_type;
    logic        keep_shamt, zero_rs, enc_legal;
    logic [5:0]  opc, func;
    logic [4:0]  rs_f, sh_f;
    logic [31:0] enc_word;

    assign id_ext    = 32'(cmd_id);
    assign handshake = cmd_valid && (state == ACCEPT);

    // Instruction ID decode; unused fields are masked so each ID has one canonical word.
    always_comb begin
        r_type     = 1'b0;
        i_type     = 1'b0;
        j_type     = 1'b0;
        keep_shamt = 1'b0;
        zero_rs    = 1'b0;
        enc_legal  = 1'b1;
        opc        = 6'b000000;
        func       = 6'b000000;
        case (id_ext)
            0:  ;
            1:  begin r_type = 1'b1; func = 6'b100000; end
            2:  begin r_type = 1'b1; func = 6'b100010; end
            3:  begin r_type = 1'b1; func = 6'b100011; end
            4:  begin r_type = 1'b1; func = 6'b100100; end
            5:  begin r_type = 1'b1; func = 6'b100101; end
            6:  begin r_type = 1'b1; func = 6'b100110; end
            7:  begin r_type = 1'b1; func = 6'b100111; end
            8:  begin r_type = 1'b1; func = 6'b101010; end
            9:  begin r_type = 1'b1; func = 6'b101011; end
            10: begin r_type = 1'b1; func = 6'b000000; keep_shamt = 1'b1; zero_rs = 1'b1; end
            11: begin r_type = 1'b1; func = 6'b000010; keep_shamt = 1'b1; zero_rs = 1'b1; end
            12: begin r_type = 1'b1; func = 6'b000011; keep_shamt = 1'b1; zero_rs = 1'b1; end
            13: begin r_type = 1'b1; func = 6'b000100; end
            14: begin r_type = 1'b1; func = 6'b000110; end
            15: begin r_type = 1'b1; func = 6'b000111; end
            16: begin r_type = 1'b1; func = 6'b001011; end
            17: begin r_type = 1'b1; func = 6'b001010; end
            18: begin i_type = 1'b1; opc = 6'b001000; end
            19: begin i_type = 1'b1; opc = 6'b001001; end
            20: begin i_type = 1'b1; opc = 6'b001010; end
            21: begin i_type = 1'b1; opc = 6'b001011; end
            22: begin i_type = 1'b1; opc = 6'b001100; end
            23: begin i_type = 1'b1; opc = 6'b001101; end
            24: begin i_type = 1'b1; opc = 6'b001110; end
            25: begin i_type = 1'b1; opc = 6'b001111; zero_rs = 1'b1; end
            26: begin i_type = 1'b1; opc = 6'b100011; end
            27: begin i_type = 1'b1; opc = 6'b101011; end
            28: begin i_type = 1'b1; opc = 6'b000100; end
            29: begin j_type = 1'b1; opc = 6'b000010; end
            default: enc_legal = 1'b0;
        endcase
    end

    // Word assembly; ID 0 and illegal IDs fall through to an all-zero word.
    always_comb begin
        rs_f     = zero_rs ? 5'd0 : cmd_rs;
        sh_f     = keep_shamt ? cmd_shamt : 5'd0;
        enc_word = 32'd0;
        if (r_type) begin
            enc_word = {6'b000000, rs_f, cmd_rt, cmd_rd, sh_f, func};
        end else if (i_type) begin
            enc_word = {opc, rs_f, cmd_rt, cmd_imm};
        end else if (j_type) begin
            enc_word = {opc, cmd_target};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = ACCEPT;
            end
            ACCEPT: begin
                if (handshake) begin
                    if (enc_legal)     state_nx = WRITE;
                    else if (cmd_last) state_nx = DONE;
                end
            end
`ifdef INST_ENC_VERIFY_EN
            WRITE:      state_nx = VERIFY_RD;
            VERIFY_RD:  state_nx = VERIFY_CMP;
            VERIFY_CMP: state_nx = last_q ? DONE : ACCEPT;
`else
            WRITE:      state_nx = last_q ? DONE : ACCEPT;
`endif
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ACCEPT);
        im_we     = (state == WRITE);
        done      = (state == DONE);
`ifdef INST_ENC_VERIFY_EN
        im_re     = (state == VERIFY_RD);
        im_addr   = (state == VERIFY_RD) ? (addr - AW'(1)) : addr;
`else
        im_re     = 1'b0;
        im_addr   = addr;
`endif
    end

    // Session datapath: write pointer, word counter, staged word and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= '0;
            count       <= '0;
            im_wdata    <= 32'd0;
            last_q      <= 1'b0;
            busy        <= 1'b0;
            err_illegal <= 1'b0;
            err_wrap    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr        <= base_addr;
                        count       <= '0;
                        busy        <= 1'b1;
                        err_illegal <= 1'b0;
                        err_wrap    <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (handshake) begin
                        im_wdata <= enc_word;
                        last_q   <= cmd_last;
                        if (!enc_legal) err_illegal <= 1'b1;
                    end
                end
                WRITE: begin
                    addr  <= addr + AW'(1);
                    count <= count + (AW+1)'(1);
                    if (addr == {AW{1'b1}}) err_wrap <= 1'b1;
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef INST_ENC_VERIFY_EN
    // Readback data arrives one cycle after im_re, i.e. while in VERIFY_CMP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_verify <= 1'b0;
        end else if (state == IDLE && start) begin
            err_verify <= 1'b0;
        end else if (state == VERIFY_CMP && im_rdata != im_wdata) begin
            err_verify <= 1'b1;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^im_rdata;
    assign err_verify   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader: expected IM writes are queued at issue time and a
// negedge monitor pops and compares them; random commands are checked against a table-driven model.
module tb_inst_encoder_loader;

    localparam int AW   = 10;
    localparam int ID_W = 5;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [ID_W-1:0] cmd_id;
    logic [4:0]      cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
    logic [15:0]     cmd_imm;
    logic [25:0]     cmd_target;
    logic            cmd_last;
    logic            im_we;
    logic [AW-1:0]   im_addr;
    logic [31:0]     im_wdata;
    logic            im_re;
    logic [31:0]     im_rdata;
    logic            busy;
    logic            done;
    logic [AW:0]     count;
    logic            err_illegal;
    logic            err_wrap;
    logic            err_verify;

    inst_encoder_loader #(.AW(AW), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
        .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .im_re(im_re), .im_rdata(im_rdata), .busy(busy), .done(done), .count(count),
        .err_illegal(err_illegal), .err_wrap(err_wrap), .err_verify(err_verify)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   word;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          writesSeen = 0;
    int          modelCount;
    logic [AW-1:0] modelAddr;
    logic        modelIllegal, modelWrap, modelVerify;
    logic        corruptRd = 1'b0;
    logic [31:0] mem [0:(1<<AW)-1];
    logic [5:0]  rFunc [0:17];
    logic [5:0]  iOp   [18:28];

    initial begin
        rFunc = '{6'h00, 6'h20, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                  6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0B, 6'h0A};
        iOp   = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04};
    end

    // Reference encoding straight from the instruction table and field-masking rules.
    function automatic logic [31:0] refWord(input int id, input logic [4:0] rs, rt, rd, sh,
                                            input logic [15:0] imm, input logic [25:0] tgt);
        logic isShift;
        isShift = (id == 10) || (id == 11) || (id == 12);
        if (id == 0 || id >= 30) return 32'd0;
        if (id <= 17) return {6'd0, isShift ? 5'd0 : rs, rt, rd, isShift ? sh : 5'd0, rFunc[id]};
        if (id <= 28) return {iOp[id], (id == 25) ? 5'd0 : rs, rt, imm};
        return {6'b000010, tgt};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // IM model: synchronous write, one-cycle read latency, optional bit-0 corruption on readback.
    always @(posedge clk) begin
        if (im_we) mem[im_addr] <= im_wdata;
        if (im_re) im_rdata <= mem[im_addr] ^ {31'd0, corruptRd};
    end

    // Monitor: every IM write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && im_we) begin
            writesSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", {22'd0, im_addr, im_wdata}, 64'hDEAD);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("im_write", {22'd0, im_addr, im_wdata}, {22'd0, e.addr, e.word});
            end
        end
    end

    task automatic startSession(input logic [AW-1:0] base);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        modelAddr = base;
        modelCount = 0;
        modelIllegal = 1'b0;
        modelWrap = 1'b0;
        modelVerify = 1'b0;
        writesSeen = 0;
    endtask

    task automatic applyStimulus(input int id, input logic [4:0] rs, rt, rd, sh,
                                 input logic [15:0] imm, input logic [25:0] tgt,
                                 input logic last, input logic [31:0] wantWord);
        logic accepted;
        if (id < 30) begin
            expQ.push_back('{modelAddr, wantWord});
            if (modelAddr == {AW{1'b1}}) modelWrap = 1'b1;
            modelAddr = modelAddr + 1'b1;
            modelCount++;
            if (corruptRd) modelVerify = 1'b1;
        end else begin
            modelIllegal = 1'b1;
        end
        cmd_id = ID_W'(id);
        cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_shamt = sh;
        cmd_imm = imm; cmd_target = tgt; cmd_last = last;
        cmd_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            if (cmd_ready) accepted = 1'b1;
        end
        if (!accepted) checkOutput("handshake_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (last) cmd_valid = 1'b0;
    endtask

    task automatic randomCmd(input logic last);
        int id;
        logic [4:0] rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        id  = ($urandom_range(0, 99) < 88) ? int'($urandom_range(0, 29)) : int'($urandom_range(30, 31));
        rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
        imm = 16'($urandom); tgt = 26'($urandom);
        applyStimulus(id, rs, rt, rd, sh, imm, tgt, last, refWord(id, rs, rt, rd, sh, imm, tgt));
    endtask

    task automatic finishSession(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput({tag, "_done"}, {63'd0, seen}, 64'd1);
        checkOutput({tag, "_count"}, {53'd0, count}, 64'(modelCount));
        checkOutput({tag, "_writes"}, 64'(writesSeen), 64'(modelCount));
        checkOutput({tag, "_errs"}, {61'd0, err_illegal, err_wrap, err_verify},
                    {61'd0, modelIllegal, modelWrap, modelVerify});
        @(negedge clk);
        checkOutput({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
        checkOutput({tag, "_pending"}, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; cmd_valid = 1'b0;
        cmd_id = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_shamt = '0;
        cmd_imm = '0; cmd_target = '0; cmd_last = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {21'd0, im_we, im_re, im_addr, cmd_ready, busy, done,
                    count, err_illegal, err_wrap, err_verify}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] basic session");
        startSession(10'h010);
        applyStimulus(19, 5'd0, 5'd1, 5'd0, 5'd0, 16'd5, 26'd0, 1'b0, 32'h24010005);
        start = 1'b1; base_addr = 10'h200;
        @(posedge clk); #1;
        start = 1'b0;
        applyStimulus(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1, 32'h00221820);
        finishSession("basic");
        checkOutput("count_held", {53'd0, count}, 64'd2);

        $display("[TB] load, jump, masking, illegal");
        startSession(10'h020);
        applyStimulus(26, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'd0, 1'b0, 32'h8FA8FFFC);
        applyStimulus(31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 26'd0, 1'b0, 32'd0);
        applyStimulus(29, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h40, 1'b0, 32'h08000040);
        applyStimulus(10, 5'd7, 5'd3, 5'd2, 5'd4, 16'hFFFF, 26'd0, 1'b0, 32'h00031100);
        applyStimulus(25, 5'd9, 5'd4, 5'd0, 5'd0, 16'hABCD, 26'd0, 1'b0, 32'h3C04ABCD);
        applyStimulus(0, 5'd5, 5'd6, 5'd7, 5'd8, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h00000000);
        finishSession("directed");

        $display("[TB] illegal as last command");
        startSession(10'h030);
        applyStimulus(30, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1, 32'd0);
        finishSession("illegal_last");

        $display("[TB] wrap");
        startSession(10'h3FF);
        applyStimulus(23, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'd0, 1'b0, 32'h344300FF);
        applyStimulus(12, 5'd1, 5'd4, 5'd5, 5'd31, 16'd0, 26'd0, 1'b1, 32'h00042FC3);
        finishSession("wrap");

        $display("[TB] random sessions");
        for (int s = 0; s < 6; s++) begin
            int n;
            n = int'($urandom_range(3, 12));
            startSession(AW'($urandom));
            for (int c = 0; c < n; c++) randomCmd(c == n - 1);
            finishSession("random");
        end

`ifdef INST_ENC_VERIFY_EN
        $display("[TB] verify with corrupted readback");
        corruptRd = 1'b1;
        startSession(10'h100);
        applyStimulus(18, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0001, 26'd0, 1'b0, 32'h20220001);
        applyStimulus(2, 5'd3, 5'd4, 5'd5, 5'd0, 16'd0, 26'd0, 1'b1, 32'h00642822);
        finishSession("verify");
        corruptRd = 1'b0;
`endif

        $display("[TB] reset during write");
        startSession(10'h150);
        applyStimulus(31, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 32'd0);
        cmd_id = ID_W'(1); cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd3; cmd_last = 1'b0;
        cmd_valid = 1'b1;
        begin
            logic accepted;
            accepted = 1'b0;
            for (int k = 0; k < 50 && !accepted; k++) begin
                @(negedge clk);
                if (cmd_ready) accepted = 1'b1;
            end
            checkOutput("rst_accept", {63'd0, accepted}, 64'd1);
        end
        @(posedge clk); #1;
        checkOutput("rst_in_write", {62'd0, im_we, err_illegal}, 64'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_outputs", {21'd0, im_we, im_re, im_addr, cmd_ready, busy, done,
                    count, err_illegal, err_wrap, err_verify}, 64'd0);
        checkOutput("rst_wdata", {32'd0, im_wdata}, 64'd0);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_idle", {61'd0, cmd_ready, busy, im_we}, 64'd0);
        expQ.delete();

        $display("[TB] session after reset");
        startSession(10'h000);
        applyStimulus(27, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0010, 26'd0, 1'b1, 32'hAFBF0010);
        finishSession("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: actual running required finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
